// File: rtl/exec_unit_mc.sv
// exec_unit_mc -- execute stage for the in-order RV64 pipeline.
//
// Sits between decode/register-read and memory/writeback. Single-cycle
// integer ALU ops and branch/jump resolution go straight into the output
// register. Divide/remainder runs a radix-2 restoring loop (XLEN iterations)
// and back-pressures decode through in_ready while it is busy.
//
// Build option:
//   EXEC_MULDIV_EN  defined   -> MUL (18) and DIV/DIVU/REM/REMU (19-22) are
//                                implemented.
//                   undefined -> no multiplier/divider; ops 18-22 complete in
//                                one cycle with out_result=0, out_illegal=1.
//   Ops 23-31 always report out_illegal=1.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               squash in-flight op / pending result (priority)
//   in_valid/in_ready   upstream handshake
//   in_op, in_use_imm   op code, select in_imm as ALU operand B
//   in_pc, in_rs1, in_rs2, in_imm, in_rd   operands and destination
//   out_valid/out_ready downstream handshake
//   out_result, out_rd, out_illegal        registered result
//   redirect_valid, redirect_pc            taken branch/jump, held with result
module exec_unit_mc #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic            in_use_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN + 1);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;
  localparam logic [4:0] OP_BEQ  = 5'd10;
  localparam logic [4:0] OP_BNE  = 5'd11;
  localparam logic [4:0] OP_BLT  = 5'd12;
  localparam logic [4:0] OP_BGE  = 5'd13;
  localparam logic [4:0] OP_BLTU = 5'd14;
  localparam logic [4:0] OP_BGEU = 5'd15;
  localparam logic [4:0] OP_JAL  = 5'd16;
  localparam logic [4:0] OP_JALR = 5'd17;
  localparam logic [4:0] OP_MUL  = 5'd18;
  localparam logic [4:0] OP_DIV  = 5'd19;
  localparam logic [4:0] OP_DIVU = 5'd20;
  localparam logic [4:0] OP_REM  = 5'd21;
  localparam logic [4:0] OP_REMU = 5'd22;

  typedef enum logic {IDLE, DIV_BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] div_cnt;

  // Two's-complement negate when requested (used for divider sign fix-up).
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] val,
                                             input logic            neg);
    return neg ? (~val + {{(XLEN-1){1'b0}}, 1'b1}) : val;
  endfunction

  // ---------------------------------------------------------------------
  // Stage p0: decode operands, combinational ALU / branch resolution
  // ---------------------------------------------------------------------
  logic        [XLEN-1:0] opb_p0;
  logic signed [XLEN-1:0] rs1_s_p0;
  logic signed [XLEN-1:0] rs2_s_p0;
  logic signed [XLEN-1:0] opb_s_p0;
  logic        [SH_W-1:0] shamt_p0;
  logic        [XLEN-1:0] pc_imm_p0;
  logic        [XLEN-1:0] link_p0;
  logic        [XLEN-1:0] jalr_sum_p0;
  logic        [XLEN-1:0] result_p0;
  logic        [XLEN-1:0] redir_pc_p0;
  logic                   taken_p0;
  logic                   illegal_p0;
  logic                   is_div_op_p0;
  logic                   accept_p0;
  logic                   accept_div_p0;
  logic                   load_alu_p0;

  assign opb_p0      = in_use_imm ? in_imm : in_rs2;
  assign rs1_s_p0    = in_rs1;
  assign rs2_s_p0    = in_rs2;
  assign opb_s_p0    = opb_p0;
  assign shamt_p0    = opb_p0[SH_W-1:0];
  assign pc_imm_p0   = in_pc + in_imm;
  assign link_p0     = in_pc + XLEN'(4);
  assign jalr_sum_p0 = in_rs1 + in_imm;

`ifdef EXEC_MULDIV_EN
  logic [XLEN-1:0] mul_lo_p0;
  assign mul_lo_p0    = in_rs1 * in_rs2;
  assign is_div_op_p0 = (in_op == OP_DIV) || (in_op == OP_DIVU) ||
                        (in_op == OP_REM) || (in_op == OP_REMU);
`else
  assign is_div_op_p0 = 1'b0;
`endif

  always_comb begin
    result_p0   = '0;
    redir_pc_p0 = '0;
    taken_p0    = 1'b0;
    illegal_p0  = 1'b0;
    case (in_op)
      OP_ADD:  result_p0 = in_rs1 + opb_p0;
      OP_SUB:  result_p0 = in_rs1 - opb_p0;
      OP_AND:  result_p0 = in_rs1 & opb_p0;
      OP_OR:   result_p0 = in_rs1 | opb_p0;
      OP_XOR:  result_p0 = in_rs1 ^ opb_p0;
      OP_SLL:  result_p0 = in_rs1 << shamt_p0;
      OP_SRL:  result_p0 = in_rs1 >> shamt_p0;
      OP_SRA:  result_p0 = rs1_s_p0 >>> shamt_p0;
      OP_SLT:  result_p0 = {{(XLEN-1){1'b0}}, (rs1_s_p0 < opb_s_p0)};
      OP_SLTU: result_p0 = {{(XLEN-1){1'b0}}, (in_rs1 < opb_p0)};
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        redir_pc_p0 = pc_imm_p0;
        case (in_op)
          OP_BEQ:  taken_p0 = (in_rs1 == in_rs2);
          OP_BNE:  taken_p0 = (in_rs1 != in_rs2);
          OP_BLT:  taken_p0 = (rs1_s_p0 <  rs2_s_p0);
          OP_BGE:  taken_p0 = (rs1_s_p0 >= rs2_s_p0);
          OP_BLTU: taken_p0 = (in_rs1 <  in_rs2);
          default: taken_p0 = (in_rs1 >= in_rs2);
        endcase
      end
      OP_JAL: begin
        result_p0   = link_p0;
        redir_pc_p0 = pc_imm_p0;
        taken_p0    = 1'b1;
      end
      OP_JALR: begin
        result_p0   = link_p0;
        redir_pc_p0 = {jalr_sum_p0[XLEN-1:1], 1'b0};
        taken_p0    = 1'b1;
      end
`ifdef EXEC_MULDIV_EN
      OP_MUL: result_p0 = mul_lo_p0;
      // Divide ops never load from here; the divider completion path does.
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: result_p0 = '0;
`else
      OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU: illegal_p0 = 1'b1;
`endif
      default: illegal_p0 = 1'b1;
    endcase
  end

  // Combinational on out_ready so single-cycle ops stream at full rate.
  assign in_ready      = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign accept_p0     = in_valid && in_ready;
  assign accept_div_p0 = accept_p0 && is_div_op_p0;
  assign load_alu_p0   = accept_p0 && !is_div_op_p0;

  // ---------------------------------------------------------------------
  // Stage p1: control FSM (IDLE / DIV_BUSY) and iteration counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept_div_p0) begin
            state   <= DIV_BUSY;
            div_cnt <= CNT_W'(XLEN);
          end
        end
        DIV_BUSY: begin
          // XLEN iterations at counts XLEN..1, result load at count 0.
          if (div_cnt == '0) state <= IDLE;
          else               div_cnt <= div_cnt - CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic load_div_p1;
  assign load_div_p1 = (state == DIV_BUSY) && (div_cnt == '0);

`ifdef EXEC_MULDIV_EN
  // ---------------------------------------------------------------------
  // Stage p1: radix-2 restoring divider on magnitudes
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] div_quo_p1;
  logic [XLEN-1:0] div_rem_p1;
  logic [XLEN-1:0] div_dvsr_p1;
  logic [XLEN-1:0] div_rs1_p1;
  logic [RD_W-1:0] div_rd_p1;
  logic            div_neg_q_p1;
  logic            div_neg_r_p1;
  logic            div_zero_p1;
  logic            div_is_rem_p1;
  logic            div_signed_p0;
  logic [XLEN-1:0] a_mag_p0;
  logic [XLEN-1:0] b_mag_p0;
  logic [XLEN:0]   rem_sh_p1;
  logic [XLEN:0]   rem_diff_p1;
  logic [XLEN-1:0] div_q_fix_p1;
  logic [XLEN-1:0] div_r_fix_p1;
  logic [XLEN-1:0] div_result_p1;

  assign div_signed_p0 = (in_op == OP_DIV) || (in_op == OP_REM);
  assign a_mag_p0      = neg_if(in_rs1, div_signed_p0 && in_rs1[XLEN-1]);
  assign b_mag_p0      = neg_if(in_rs2, div_signed_p0 && in_rs2[XLEN-1]);

  assign rem_sh_p1   = {div_rem_p1, div_quo_p1[XLEN-1]};
  assign rem_diff_p1 = rem_sh_p1 - {1'b0, div_dvsr_p1};

  always_ff @(posedge clk) begin
    if (accept_div_p0) begin
      div_quo_p1    <= a_mag_p0;
      div_rem_p1    <= '0;
      div_dvsr_p1   <= b_mag_p0;
      div_rs1_p1    <= in_rs1;
      div_rd_p1     <= in_rd;
      div_neg_q_p1  <= div_signed_p0 && (in_rs1[XLEN-1] ^ in_rs2[XLEN-1]);
      div_neg_r_p1  <= div_signed_p0 && in_rs1[XLEN-1];
      div_zero_p1   <= (in_rs2 == '0);
      div_is_rem_p1 <= (in_op == OP_REM) || (in_op == OP_REMU);
    end else if ((state == DIV_BUSY) && (div_cnt != '0)) begin
      // Negative trial difference (MSB set) means restore.
      if (!rem_diff_p1[XLEN]) begin
        div_rem_p1 <= rem_diff_p1[XLEN-1:0];
        div_quo_p1 <= {div_quo_p1[XLEN-2:0], 1'b1};
      end else begin
        div_rem_p1 <= rem_sh_p1[XLEN-1:0];
        div_quo_p1 <= {div_quo_p1[XLEN-2:0], 1'b0};
      end
    end
  end

  // MIN / -1 falls out naturally: |MIN| / 1 = 2^(XLEN-1) with no negate,
  // which reads back as MIN, remainder 0. Divide-by-zero is overridden.
  always_comb begin
    div_q_fix_p1 = neg_if(div_quo_p1, div_neg_q_p1);
    div_r_fix_p1 = neg_if(div_rem_p1, div_neg_r_p1);
    if (div_zero_p1) begin
      div_q_fix_p1 = '1;
      div_r_fix_p1 = div_rs1_p1;
    end
    div_result_p1 = div_is_rem_p1 ? div_r_fix_p1 : div_q_fix_p1;
  end
`endif

  // ---------------------------------------------------------------------
  // Stage p2: output register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid      <= 1'b0;
      redirect_valid <= 1'b0;
      out_illegal    <= 1'b0;
      out_result     <= '0;
      out_rd         <= '0;
      redirect_pc    <= '0;
    end else if (flush) begin
      out_valid      <= 1'b0;
      redirect_valid <= 1'b0;
    end else if (load_alu_p0) begin
      out_valid      <= 1'b1;
      out_result     <= result_p0;
      out_rd         <= in_rd;
      out_illegal    <= illegal_p0;
      redirect_valid <= taken_p0;
      redirect_pc    <= redir_pc_p0;
    end else if (load_div_p1) begin
      // A divide is only accepted when the output register is free, and
      // in_ready stays low while busy, so nothing can be pending here.
      out_valid      <= 1'b1;
`ifdef EXEC_MULDIV_EN
      out_result     <= div_result_p1;
      out_rd         <= div_rd_p1;
`else
      out_result     <= '0;
      out_rd         <= '0;
`endif
      out_illegal    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else if (out_valid && out_ready) begin
      out_valid      <= 1'b0;
      redirect_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed testbench for exec_unit_mc (XLEN=64, RD_W=5).
module tb_exec_unit_mc;

  localparam int XLEN = 64;
  localparam int RD_W = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_op;
  logic            in_use_imm;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  logic [RD_W-1:0] in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [RD_W-1:0] out_rd;
  logic            out_illegal;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  int vectors     = 0;
  int miscompares = 0;

  exec_unit_mc #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_use_imm     (in_use_imm),
    .in_pc          (in_pc),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_imm         (in_imm),
    .in_rd          (in_rd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_rd         (out_rd),
    .out_illegal    (out_illegal),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic use_imm,
                       input logic [63:0] pc, input logic [63:0] rs1,
                       input logic [63:0] rs2, input logic [63:0] imm,
                       input logic [4:0] rd);
    in_valid   = 1'b1;
    in_op      = op;
    in_use_imm = use_imm;
    in_pc      = pc;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_imm     = imm;
    in_rd      = rd;
    #1;
  endtask

`ifdef EXEC_MULDIV_EN
  task automatic run_div(input string tag, input logic [4:0] op,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp);
    logic early;
    early = 1'b0;
    issue(op, 1'b0, 64'h0, a, b, 64'h0, 5'd12);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i <= XLEN; i++) begin
      if (out_valid || in_ready) early = 1'b1;
      tick();
    end
    chk({tag, "_busy"}, {63'd0, early}, 64'd0);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_result"}, out_result, exp);
    tick();
  endtask
`endif

  initial begin
    logic seen;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 5'd0; in_use_imm = 1'b0;
    in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_rd = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid",  {63'd0, out_valid}, 64'd0);
    chk("rst_redir_valid", {63'd0, redirect_valid}, 64'd0);
    chk("rst_illegal",    {63'd0, out_illegal}, 64'd0);
    chk("rst_result",     out_result, 64'd0);
    chk("rst_rd",         {59'd0, out_rd}, 64'd0);
    chk("rst_redir_pc",   redirect_pc, 64'd0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

    // ALU ops back to back
    issue(5'd0, 1'b0, 64'h0, 64'd5, 64'd7, 64'h0, 5'd3);
    chk("add_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("add_valid",  {63'd0, out_valid}, 64'd1);
    chk("add_result", out_result, 64'd12);
    chk("add_rd",     {59'd0, out_rd}, 64'd3);
    issue(5'd1, 1'b0, 64'h0, 64'd5, 64'd7, 64'h0, 5'd4);
    chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("sub_result", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(5'd0, 1'b1, 64'h0, 64'd10, 64'd99, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5);
    tick();
    chk("addi_result", out_result, 64'd7);
    issue(5'd7, 1'b1, 64'h0, 64'h8000_0000_0000_0000, 64'd0, 64'd4, 5'd5);
    tick();
    chk("srai_result", out_result, 64'hF800_0000_0000_0000);
    issue(5'd5, 1'b0, 64'h0, 64'd1, 64'h41, 64'h0, 5'd5);
    tick();
    chk("sll_shamt_mask", out_result, 64'd2);
    issue(5'd9, 1'b0, 64'h0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 5'd5);
    tick();
    chk("sltu_result", out_result, 64'd1);
    issue(5'd8, 1'b0, 64'h0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 5'd5);
    tick();
    chk("slt_result", out_result, 64'd0);

    // Branches and jumps
    issue(5'd11, 1'b1, 64'h100, 64'd1, 64'd2, 64'h20, 5'd0);
    tick();
    chk("bne_redir_valid", {63'd0, redirect_valid}, 64'd1);
    chk("bne_redir_pc",    redirect_pc, 64'h120);
    chk("bne_result",      out_result, 64'd0);
    issue(5'd10, 1'b1, 64'h100, 64'd1, 64'd2, 64'h20, 5'd0);
    tick();
    chk("beq_redir_valid", {63'd0, redirect_valid}, 64'd0);
    chk("beq_out_valid",   {63'd0, out_valid}, 64'd1);
    issue(5'd12, 1'b0, 64'h400, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h8, 5'd0);
    tick();
    chk("blt_redir_valid", {63'd0, redirect_valid}, 64'd1);
    chk("blt_redir_pc",    redirect_pc, 64'h408);
    issue(5'd14, 1'b0, 64'h400, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h8, 5'd0);
    tick();
    chk("bltu_redir_valid", {63'd0, redirect_valid}, 64'd0);
    issue(5'd17, 1'b1, 64'h200, 64'h1001, 64'd0, 64'd4, 5'd1);
    tick();
    chk("jalr_redir_valid", {63'd0, redirect_valid}, 64'd1);
    chk("jalr_redir_pc",    redirect_pc, 64'h1004);
    chk("jalr_result",      out_result, 64'h204);
    issue(5'd16, 1'b1, 64'h300, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 5'd1);
    tick();
    chk("jal_redir_pc", redirect_pc, 64'h2F0);
    chk("jal_result",   out_result, 64'h304);

    // Illegal op codes
    issue(5'd25, 1'b0, 64'h0, 64'd3, 64'd4, 64'h0, 5'd2);
    tick();
    chk("op25_illegal", {63'd0, out_illegal}, 64'd1);
    chk("op25_result",  out_result, 64'd0);
    chk("op25_redir",   {63'd0, redirect_valid}, 64'd0);

`ifdef EXEC_MULDIV_EN
    issue(5'd18, 1'b0, 64'h0, 64'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0, 5'd2);
    tick();
    chk("mul_result",  out_result, 64'hFFFF_FFFF_FFFF_FFD6);
    chk("mul_illegal", {63'd0, out_illegal}, 64'd0);
    in_valid = 1'b0;
    tick();
    run_div("div_neg", 5'd19, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_div("rem_neg", 5'd21, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_div("divu_zero", 5'd20, 64'd1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_div("remu_zero", 5'd22, 64'd1234, 64'd0, 64'd1234);
    run_div("div_ovf", 5'd19, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000);
    run_div("divu_big", 5'd20, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF);

    // Flush five cycles into a divide
    issue(5'd19, 1'b0, 64'h0, 64'd100, 64'd3, 64'h0, 5'd9);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("div_flush_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < XLEN + 4; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("div_flush_no_result", {63'd0, seen}, 64'd0);

    // Reset five cycles into a divide
    issue(5'd19, 1'b0, 64'h0, 64'd100, 64'd3, 64'h0, 5'd9);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < XLEN + 4; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("div_reset_no_result", {63'd0, seen}, 64'd0);
    chk("div_reset_in_ready",  {63'd0, in_ready}, 64'd1);
`else
    issue(5'd19, 1'b0, 64'h0, 64'd100, 64'd3, 64'h0, 5'd2);
    chk("div_off_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("div_off_valid",   {63'd0, out_valid}, 64'd1);
    chk("div_off_illegal", {63'd0, out_illegal}, 64'd1);
    chk("div_off_result",  out_result, 64'd0);
    issue(5'd18, 1'b0, 64'h0, 64'd6, 64'd7, 64'h0, 5'd2);
    chk("mul_off_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("mul_off_illegal", {63'd0, out_illegal}, 64'd1);
    chk("mul_off_result",  out_result, 64'd0);
`endif

    // Back-pressure: hold result for three cycles
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {63'd0, out_valid}, 64'd0);
    issue(5'd0, 1'b0, 64'h0, 64'd100, 64'd1, 64'h0, 5'd7);
    tick();
    out_ready = 1'b0;
    issue(5'd4, 1'b0, 64'h0, 64'hF0, 64'h0F, 64'h0, 5'd8);
    chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid",  {63'd0, out_valid}, 64'd1);
      chk("bp_hold_result", out_result, 64'd101);
      chk("bp_hold_rd",     {59'd0, out_rd}, 64'd7);
      chk("bp_hold_ready",  {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("bp_next_result", out_result, 64'hFF);
    chk("bp_next_rd",     {59'd0, out_rd}, 64'd8);
    in_valid = 1'b0;
    tick();
    chk("bp_cleared", {63'd0, out_valid}, 64'd0);

    // Flush over a pending taken jump, with a new op offered
    issue(5'd16, 1'b1, 64'h500, 64'd0, 64'd0, 64'h40, 5'd9);
    tick();
    chk("pre_flush_redir", {63'd0, redirect_valid}, 64'd1);
    flush = 1'b1;
    issue(5'd0, 1'b0, 64'h0, 64'd1, 64'd1, 64'h0, 5'd10);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_redir",     {63'd0, redirect_valid}, 64'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("flush_dropped", {63'd0, out_valid}, 64'd0);

    // Reset over a pending jump clears every output
    issue(5'd16, 1'b1, 64'h600, 64'd0, 64'd0, 64'h10, 5'd11);
    tick();
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("rst2_out_valid",   {63'd0, out_valid}, 64'd0);
    chk("rst2_redir_valid", {63'd0, redirect_valid}, 64'd0);
    chk("rst2_result",      out_result, 64'd0);
    chk("rst2_rd",          {59'd0, out_rd}, 64'd0);
    chk("rst2_redir_pc",    redirect_pc, 64'd0);
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
